// File: rtl/gate_response_checker.sv
// -----------------------------------------------------------------------------
// gate_response_checker
//
// Sweep-and-check engine for 2-input gate models. On a start request it drives
// every {a,b} combination (00, 01, 10, 11) into the gate under test. It holds
// each vector for SETTLE_CYCLES cycles and then samples the gate output for one
// cycle. Each sample is compared against TRUTH_TABLE. When the sweep ends it
// reports a pass flag, a mismatch count and a per-vector fail map.
//
// Parameters:
//   TRUTH_TABLE   expected gate output, bit index = {a,b} (default OR)
//   SETTLE_CYCLES cycles each vector is held before sampling (1..255)
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous reset, active-low
//   start        sweep request, honoured only while idle
//   gate_out     output of the gate under test
//   stim_a       gate input a (MSB of the vector index)
//   stim_b       gate input b (LSB of the vector index)
//   busy         high from the first drive cycle through the last sample cycle
//   done         one-cycle pulse when a sweep completes
//   pass         1 = no mismatches in the last completed sweep
//   err_count    number of mismatching vectors (0..4)
//   fail_vector  bit i set = mismatch at vector index i
// -----------------------------------------------------------------------------
module gate_response_checker #(
  parameter logic [3:0]  TRUTH_TABLE   = 4'b1110,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gate_out,
  output logic       stim_a,
  output logic       stim_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vector
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  // Last value of the settle counter before moving on to the sample cycle.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] err_d;
  logic [3:0] fail_d;
  logic       pass_d;
  logic       drive_d;

  // NOTE: every signal is given a default before the case statement, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_count;
    fail_d  = fail_vector;
    pass_d  = pass;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 2'd0;
          cnt_d   = 8'd0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SAMPLE: begin
        if (gate_out != TRUTH_TABLE[idx_q]) begin
          fail_d[idx_q] = 1'b1;
          err_d         = err_count + 3'd1;
        end
        // The index == 3 check comes before the increment, so the 2-bit
        // index never wraps inside a sweep.
        if (idx_q == 2'd3) begin
          state_d = DONE;
          // Use the count that already includes this final sample.
          pass_d  = (err_d == 3'd0);
        end else begin
          state_d = DRIVE;
          idx_d   = idx_q + 2'd1;
          cnt_d   = 8'd0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stimulus and busy follow the state being entered, so they line up with
  // that state's cycle.
  assign drive_d = (state_d == DRIVE) || (state_d == SAMPLE);

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values that were present before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 8'd0;
      stim_a      <= 1'b0;
      stim_b      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= 3'd0;
      fail_vector <= 4'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      stim_a      <= drive_d ? idx_d[1] : 1'b0;
      stim_b      <= drive_d ? idx_d[0] : 1'b0;
      busy        <= drive_d;
      done        <= (state_d == DONE);
      pass        <= pass_d;
      err_count   <= err_d;
      fail_vector <= fail_d;
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_response_checker
//
// Self-checking bench for gate_response_checker. It uses two instances:
//   dut0 - default parameters (OR truth table, SETTLE_CYCLES = 2)
//   dut1 - OR truth table, SETTLE_CYCLES = 1
// A small behavioural gate sits on each instance and can act as OR, AND or a
// constant 1. When a sweep starts, the expected sweep results are queued.
// They are popped and compared when the done pulse appears. Stimulus, busy
// and done are checked cycle by cycle against the documented timing.
// -----------------------------------------------------------------------------
module tb_gate_response_checker;

  localparam logic [3:0] TT = 4'b1110;

  typedef struct {
    logic [3:0] fv;
    logic [2:0] ec;
    logic       ps;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic gate0, gate1;
  int   g0 = 0, g1 = 0;
  int   sel = 0;

  logic       sa0, sb0, bz0, dn0, ps0;
  logic [2:0] ec0;
  logic [3:0] fv0;
  logic       sa1, sb1, bz1, dn1, ps1;
  logic [2:0] ec1;
  logic [3:0] fv1;

  // Outputs of the instance currently being exercised.
  logic       sa, sb, bz, dn, ps;
  logic [2:0] ec;
  logic [3:0] fv;

  always #5 clk = ~clk;

  // Gate model: 0 = OR, 1 = AND, 2 = constant 1.
  function automatic logic gate_fn(input int g, input logic a, input logic b);
    case (g)
      0:       return a | b;
      1:       return a & b;
      default: return 1'b1;
    endcase
  endfunction

  always_comb gate0 = gate_fn(g0, sa0, sb0);
  always_comb gate1 = gate_fn(g1, sa1, sb1);

  always_comb begin
    if (sel == 0) begin
      sa = sa0; sb = sb0; bz = bz0; dn = dn0; ps = ps0; ec = ec0; fv = fv0;
    end else begin
      sa = sa1; sb = sb1; bz = bz1; dn = dn1; ps = ps1; ec = ec1; fv = fv1;
    end
  end

  gate_response_checker dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .gate_out(gate0),
    .stim_a(sa0), .stim_b(sb0), .busy(bz0), .done(dn0), .pass(ps0),
    .err_count(ec0), .fail_vector(fv0)
  );

  gate_response_checker #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .gate_out(gate1),
    .stim_a(sa1), .stim_b(sb1), .busy(bz1), .done(dn1), .pass(ps1),
    .err_count(ec1), .fail_vector(fv1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) start0 = v;
    else        start1 = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stim"},  {30'd0, sa, sb}, 32'd0);
    check({tag, "_busy"},  {31'd0, bz}, 32'd0);
    check({tag, "_done"},  {31'd0, dn}, 32'd0);
    check({tag, "_pass"},  {31'd0, ps}, 32'd0);
    check({tag, "_err"},   {29'd0, ec}, 32'd0);
    check({tag, "_fail"},  {28'd0, fv}, 32'd0);
  endtask

  // Run one sweep on instance d with gate model g and settle time s.
  // r1/r2 are cycles in which start is asserted again (0 = none).
  // tail is the number of cycles checked after the done cycle.
  task automatic run_sweep(input int d, input int g, input int s,
                           input int r1, input int r2, input int tail);
    exp_t e, got;
    int   done_c, v, ndone;
    sel = d;
    @(negedge clk);
    if (d == 0) g0 = g;
    else        g1 = g;
    for (int i = 0; i < 4; i++) begin
      e.fv[i] = (gate_fn(g, i[1], i[0]) != TT[i]);
    end
    e.ec = 3'(e.fv[0]) + 3'(e.fv[1]) + 3'(e.fv[2]) + 3'(e.fv[3]);
    e.ps = (e.ec == 3'd0);
    sb_q.push_back(e);
    set_start(d, 1'b1);
    done_c = 1 + 4 * (s + 1);
    ndone  = 0;
    for (int c = 1; c <= done_c + tail; c++) begin
      @(negedge clk);
      if (dn) ndone++;
      if (c == 1) begin
        check("clear_err",  {29'd0, ec}, 32'd0);
        check("clear_fail", {28'd0, fv}, 32'd0);
        check("clear_pass", {31'd0, ps}, 32'd0);
      end
      if (c < done_c) begin
        v = (c - 1) / (s + 1);
        check("stim", {30'd0, sa, sb}, 32'(v));
        check("busy", {31'd0, bz}, 32'd1);
        check("done", {31'd0, dn}, 32'd0);
      end else begin
        check("stim_idle", {30'd0, sa, sb}, 32'd0);
        check("busy_idle", {31'd0, bz}, 32'd0);
        check("done_pulse", {31'd0, dn}, (c == done_c) ? 32'd1 : 32'd0);
        if (c == done_c) begin
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
          end else begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
          end
        end
        got.fv = fv; got.ec = ec; got.ps = ps;
        check("fail_vector", {28'd0, got.fv}, {28'd0, e.fv});
        check("err_count",   {29'd0, got.ec}, {29'd0, e.ec});
        check("pass",        {31'd0, got.ps}, {31'd0, e.ps});
      end
      set_start(d, (c == r1) || (c == r2));
    end
    check("done_count", 32'(ndone), 32'd1);
    set_start(d, 1'b0);
  endtask

  initial begin
    // Reset state of both instances.
    #3;
    sel = 0; #1; check_all_zero("rst0");
    sel = 1; #1; check_all_zero("rst1");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Correct OR gate, AND gate, gate output tied to 1.
    run_sweep(0, 0, 2, 0, 0, 2);
    run_sweep(0, 1, 2, 0, 0, 2);
    run_sweep(0, 2, 2, 0, 0, 2);

    // start re-asserted during vector 2 (cycle 8) and in the DONE cycle (13).
    run_sweep(0, 0, 2, 8, 13, 4);

    // Reset during DRIVE of vector 1. The tied-1 gate has already produced
    // one mismatch at this point.
    sel = 0;
    @(negedge clk);
    g0 = 2;
    start0 = 1'b1;
    @(negedge clk);  // cycle 1
    start0 = 1'b0;
    repeat (4) @(negedge clk);  // cycle 5: DRIVE of vector 1
    check("pre_rst_stim", {30'd0, sa, sb}, 32'd1);
    check("pre_rst_err",  {29'd0, ec}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      check("no_done_after_rst", {31'd0, dn}, 32'd0);
      check("idle_after_rst", {31'd0, bz}, 32'd0);
    end
    run_sweep(0, 0, 2, 0, 0, 1);

    // SETTLE_CYCLES = 1: faulty sweep, then a correct sweep whose start is
    // asserted in the cycle after DONE.
    run_sweep(1, 1, 1, 0, 0, 0);
    run_sweep(1, 0, 1, 0, 0, 2);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
